// File: rtl/depacketizer_buffered.sv
// Depacketizer with framing check and registered output FIFO.
// Strips per-flit control, concatenates valid-flit payloads, drops malformed
// packets (sticky error + saturating drop counter) and queues good ones.
module depacketizer_buffered #(
    parameter int WIDTH_PKT        = 36,
    parameter int NUM_FLITS        = 4,
    parameter int WIDTH_DATA       = 12,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int DEPTH            = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH_PKT-1:0]           i_packet_in,
    output logic                           i_ready_out,
    output logic [WIDTH_DATA-1:0]          o_data_out,
    output logic [VC_ADDRESS_WIDTH-1:0]    o_vc_out,
    output logic [$clog2(NUM_FLITS+1)-1:0] o_nflits_out,
    output logic                           o_valid_out,
    input  logic                           o_ready_in,
    output logic                           o_error,
    output logic [7:0]                     o_drop_count
);
    localparam int WIDTH_FLIT     = WIDTH_PKT / NUM_FLITS;
    localparam int WIDTH_DATA_IDL = WIDTH_PKT - NUM_FLITS*(3+VC_ADDRESS_WIDTH) - ADDRESS_WIDTH;
    localparam int PW_HEAD        = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
    localparam int PW_BODY        = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
    localparam int NW             = $clog2(NUM_FLITS+1);
    localparam int PTRW           = $clog2(DEPTH);
    localparam int CW             = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WIDTH_DATA-1:0]       data;
        logic [VC_ADDRESS_WIDTH-1:0] vc;
        logic [NW-1:0]               nflits;
    } entry_t;

    logic [NUM_FLITS-1:0]      f_valid, f_head, f_tail;
    logic [WIDTH_DATA_IDL-1:0] assembled;

    // Per-flit control extraction and payload placement (invalid flits zeroed)
    for (genvar k = 0; k < NUM_FLITS; k++) begin : g_flit
        logic [WIDTH_FLIT-1:0] flit;
        assign flit       = i_packet_in[(NUM_FLITS-k)*WIDTH_FLIT-1 -: WIDTH_FLIT];
        assign f_valid[k] = flit[WIDTH_FLIT-1];
        assign f_head[k]  = flit[WIDTH_FLIT-2];
        assign f_tail[k]  = flit[WIDTH_FLIT-3];
        if (k == 0) begin : g_head
            assign assembled[WIDTH_DATA_IDL-1 -: PW_HEAD] =
                flit[PW_HEAD-1:0] & {PW_HEAD{flit[WIDTH_FLIT-1]}};
        end else begin : g_body
            assign assembled[(NUM_FLITS-k)*PW_BODY-1 -: PW_BODY] =
                flit[PW_BODY-1:0] & {PW_BODY{flit[WIDTH_FLIT-1]}};
        end
    end

    // Dest field, body VC fields and low payload bits are intentionally dropped
    logic unused_bits;
    assign unused_bits = ^{i_packet_in, assembled};

    logic          frame_err;
    logic [NW-1:0] nflits;

    // Locate the first valid tail and validate head/tail framing around it
    always_comb begin
        logic tail_found, gap;
        tail_found = 1'b0;
        gap        = 1'b0;
        nflits     = '0;
        frame_err  = ~f_head[0];
        for (int k = 0; k < NUM_FLITS; k++) begin
            if (k > 0 && f_head[k]) frame_err = 1'b1;
            if (tail_found) begin
                if (f_valid[k]) frame_err = 1'b1;
            end else if (f_valid[k] && f_tail[k]) begin
                tail_found = 1'b1;
                nflits     = NW'(k + 1);
                if (gap) frame_err = 1'b1;
            end else if (!f_valid[k]) begin
                gap = 1'b1;
            end
        end
        if (!tail_found) frame_err = 1'b1;
    end

    entry_t          mem [DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            accept, push, pop;
    entry_t          new_entry, head_entry;

    assign i_ready_out = (count < CW'(DEPTH));
    assign o_valid_out = (count != '0);
    assign accept      = i_packet_in[WIDTH_PKT-1] && i_ready_out;
    assign push        = accept && !frame_err;
    assign pop         = o_valid_out && o_ready_in;

    assign new_entry.data   = assembled[WIDTH_DATA_IDL-1 -: WIDTH_DATA];
    assign new_entry.vc     = i_packet_in[WIDTH_PKT-4 -: VC_ADDRESS_WIDTH];
    assign new_entry.nflits = nflits;

    assign head_entry   = mem[rd_ptr];
    assign o_data_out   = head_entry.data;
    assign o_vc_out     = head_entry.vc;
    assign o_nflits_out = head_entry.nflits;

    // Circular buffer storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Sticky framing error and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_error      <= 1'b0;
            o_drop_count <= '0;
        end else if (accept && frame_err) begin
            o_error <= 1'b1;
            if (o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_depacketizer_buffered.sv
// Directed bench for depacketizer_buffered: vector table plus hand sequences.
module tb_depacketizer_buffered;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [35:0] i_packet_in;
    logic        i_ready_out;
    logic [11:0] o_data_out;
    logic [0:0]  o_vc_out;
    logic [2:0]  o_nflits_out;
    logic        o_valid_out;
    logic        o_ready_in;
    logic        o_error;
    logic [7:0]  o_drop_count;

    int tests = 0;
    int fails = 0;

    depacketizer_buffered dut (
        .clk(clk), .rst_n(rst_n), .i_packet_in(i_packet_in), .i_ready_out(i_ready_out),
        .o_data_out(o_data_out), .o_vc_out(o_vc_out), .o_nflits_out(o_nflits_out),
        .o_valid_out(o_valid_out), .o_ready_in(o_ready_in), .o_error(o_error),
        .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] fh(input logic v, h, t, c, input logic [3:0] d, input logic p);
        return {v, h, t, c, d, p};
    endfunction

    function automatic logic [8:0] fb(input logic v, h, t, c, input logic [4:0] p);
        return {v, h, t, c, p};
    endfunction

    // Good 4-flit packet, vc 0, second-flit payload j -> data = j << 6
    function automatic logic [35:0] mk(input logic [4:0] j);
        return {fh(1,1,0,0,4'h2,1'b0), fb(1,0,0,0,j), fb(1,0,0,0,5'h0), fb(1,0,1,0,5'h0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [35:0] p, input logic r);
        i_packet_in = p;
        o_ready_in  = r;
        @(negedge clk);
    endtask

    typedef struct {
        logic [35:0] pkt;
        int          kind;   // 0 good, 1 malformed, 2 not presented
        logic [11:0] data;
        logic        vc;
        logic [2:0]  nf;
    } vec_t;

    vec_t tv[12];
    int   drop_m;
    logic err_m;

    initial begin
        tv[0]  = '{{fh(1,1,0,1,4'h3,1'b1), fb(1,0,0,1,5'h1F), fb(1,0,0,1,5'h00), fb(1,0,1,1,5'h15)}, 0, 12'hFC1, 1'b1, 3'd4};
        tv[1]  = '{{fh(1,1,1,0,4'h0,1'b1), fb(0,0,0,0,5'h1F), fb(0,0,0,1,5'h0A), fb(0,0,1,0,5'h1F)}, 0, 12'h800, 1'b0, 3'd1};
        tv[2]  = '{{fh(1,1,0,1,4'h5,1'b0), fb(1,0,1,1,5'h0A), fb(0,0,0,0,5'h1F), fb(0,0,0,0,5'h03)}, 0, 12'h280, 1'b1, 3'd2};
        tv[3]  = '{{fh(1,1,0,0,4'h0,1'b1), fb(1,0,0,0,5'h03), fb(1,0,1,0,5'h11), fb(0,0,0,0,5'h1F)}, 0, 12'h8E2, 1'b0, 3'd3};
        tv[4]  = '{{fh(1,1,0,0,4'hF,1'b1), fb(1,0,0,0,5'h1F), fb(1,0,0,0,5'h1F), fb(1,0,1,0,5'h1F)}, 0, 12'hFFF, 1'b0, 3'd4};
        tv[5]  = '{{fh(0,1,1,1,4'hF,1'b1), fb(1,0,0,0,5'h1F), fb(1,0,1,0,5'h1F), fb(0,0,0,0,5'h00)}, 2, 12'h0, 1'b0, 3'd0};
        tv[6]  = '{{fh(1,1,0,1,4'h3,1'b1), fb(1,0,0,1,5'h1F), fb(1,0,0,1,5'h00), fb(1,0,0,1,5'h15)}, 1, 12'h0, 1'b0, 3'd0};
        tv[7]  = '{{fh(1,0,1,0,4'h0,1'b1), fb(0,0,0,0,5'h00), fb(0,0,0,0,5'h00), fb(0,0,0,0,5'h00)}, 1, 12'h0, 1'b0, 3'd0};
        tv[8]  = '{{fh(1,1,0,0,4'h0,1'b1), fb(1,0,0,0,5'h01), fb(1,1,0,0,5'h02), fb(1,0,1,0,5'h03)}, 1, 12'h0, 1'b0, 3'd0};
        tv[9]  = '{{fh(1,1,1,0,4'h0,1'b1), fb(1,0,0,0,5'h04), fb(0,0,0,0,5'h00), fb(0,0,0,0,5'h00)}, 1, 12'h0, 1'b0, 3'd0};
        tv[10] = '{{fh(1,1,0,0,4'h0,1'b1), fb(0,0,0,0,5'h00), fb(1,0,1,0,5'h05), fb(0,0,0,0,5'h00)}, 1, 12'h0, 1'b0, 3'd0};
        tv[11] = tv[3];

        // Reset state
        rst_n = 1'b0; i_packet_in = '0; o_ready_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", o_valid_out, 0);
        chk("rst_ready", i_ready_out, 1);
        chk("rst_error", o_error, 0);
        chk("rst_drop", o_drop_count, 0);
        chk("rst_data", {o_data_out, o_vc_out, o_nflits_out}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, downstream always ready: each packet is visible one cycle
        drop_m = 0; err_m = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(tv[i].pkt, 1'b1);
            if (tv[i].kind == 1) begin drop_m++; err_m = 1'b1; end
            if (tv[i].kind == 0) begin
                chk($sformatf("v%0d_valid", i), o_valid_out, 1);
                chk($sformatf("v%0d_data", i), o_data_out, tv[i].data);
                chk($sformatf("v%0d_vc", i), o_vc_out, tv[i].vc);
                chk($sformatf("v%0d_nflits", i), o_nflits_out, tv[i].nf);
            end else begin
                chk($sformatf("v%0d_valid", i), o_valid_out, 0);
            end
            chk($sformatf("v%0d_error", i), o_error, err_m);
            chk($sformatf("v%0d_drop", i), o_drop_count, drop_m);
        end
        step('0, 1'b1);

        // Drop counter saturation
        for (int i = 0; i < 250; i++) step(tv[6].pkt, 1'b1);
        chk("sat_reach", o_drop_count, 255);
        for (int i = 0; i < 50; i++) step(tv[7].pkt, 1'b1);
        chk("sat_hold", o_drop_count, 255);
        chk("sat_valid", o_valid_out, 0);

        // Async reset with 3 entries queued and error set
        for (int j = 1; j <= 3; j++) step(mk(5'(j)), 1'b0);
        step('0, 1'b0);
        chk("pre_rst_valid", o_valid_out, 1);
        chk("pre_rst_error", o_error, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid_out, 0);
        chk("mid_rst_error", o_error, 0);
        chk("mid_rst_drop", o_drop_count, 0);
        chk("mid_rst_ready", i_ready_out, 1);
        chk("mid_rst_data", {o_data_out, o_vc_out, o_nflits_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Backpressure: five packets offered, four fit; then drain in order
        begin
            logic [35:0] bp  [5];
            logic [11:0] bpd [5];
            int          p;
            logic        acc;
            bpd = '{12'h040, 12'h080, 12'h0C0, 12'h100, 12'h140};
            for (int j = 0; j < 5; j++) bp[j] = mk(5'(j + 1));
            p = 0;
            for (int c = 0; c < 5; c++) begin
                acc = i_ready_out;
                step(bp[p], 1'b0);
                if (acc) p++;
            end
            chk("bp_accepted", p, 4);
            chk("bp_ready_full", i_ready_out, 0);
            for (int j = 0; j < 5; j++) begin
                chk($sformatf("bp_valid%0d", j), o_valid_out, 1);
                chk($sformatf("bp_data%0d", j), o_data_out, bpd[j]);
                if (j == 0) chk("bp_ready_before_pop", i_ready_out, 0);
                if (j == 1) chk("bp_ready_after_pop", i_ready_out, 1);
                acc = i_ready_out;
                step((p < 5) ? bp[p] : 36'h0, 1'b1);
                if (acc && p < 5) p++;
            end
            chk("bp_empty", o_valid_out, 0);
        end

        // Simultaneous push/pop at count 2
        step(mk(5'd6), 1'b0);
        step(mk(5'd7), 1'b0);
        chk("pp_head_a", o_data_out, 12'h180);
        step(mk(5'd8), 1'b1);
        chk("pp_head_b", o_data_out, 12'h1C0);
        chk("pp_ready", i_ready_out, 1);
        step(mk(5'd9), 1'b1);
        chk("pp_head_c", o_data_out, 12'h200);
        step('0, 1'b1);
        chk("pp_valid_d", o_valid_out, 1);
        chk("pp_head_d", o_data_out, 12'h240);
        step('0, 1'b1);
        chk("pp_empty", o_valid_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
